// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array output side.
package systolic_pkg;

  localparam int DEF_SIZE       = 6;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int RES_W          = 2 * DEF_DATA_WIDTH;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_result_drain.sv
// Snapshots the systolic array result on done's rising edge and streams it
// row-major, one element per beat, over a valid/ready interface.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_W      = idx_width(SIZE)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        done,
  input  logic [0:SIZE-1][0:SIZE-1][2*DATA_WIDTH-1:0] result,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [2*DATA_WIDTH-1:0]                     out_data,
  output logic [IDX_W-1:0]                            out_row,
  output logic [IDX_W-1:0]                            out_col,
  output logic                                        out_last,
  output logic                                        busy,
  output logic                                        frame_done,
  output logic                                        overrun
);

  localparam int              ELEM_W   = 2 * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  state_e                  state_q;
  logic                    done_q;
  logic                    valid_q, last_q, busy_q, frame_done_q, overrun_q;
  logic [ELEM_W-1:0]       data_q;
  logic [IDX_W-1:0]        row_q, col_q;
  logic [ELEM_W-1:0]       snap_q [SIZE][SIZE];

  logic                    trig, xfer, final_xfer, start;
  logic [IDX_W-1:0]        row_d, col_d;
  logic                    last_d;

  assign trig       = done & ~done_q;
  assign xfer       = valid_q & out_ready;
  assign final_xfer = xfer & last_q;
  // A trigger landing on the final transfer chains straight into the next frame.
  assign start      = trig & ((state_q == IDLE) | final_xfer);

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // a missed branch infers a latch.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == LAST_IDX) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end
    last_d = (row_d == LAST_IDX) && (col_d == LAST_IDX);
  end

  // NOTE: the snapshot is a data-only array with no reset; its contents are
  // only read after a capture, so clearing it would just cost reset fanout.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          snap_q[i][j] <= result[i][j];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      done_q       <= 1'b1;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      data_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
    end else begin
      done_q       <= done;
      frame_done_q <= final_xfer;
      if (trig && (state_q == STREAM) && !final_xfer) begin
        overrun_q <= 1'b1;
      end
      if (start) begin
        state_q <= STREAM;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
        row_q   <= '0;
        col_q   <= '0;
        last_q  <= (SIZE == 1);
        data_q  <= result[0][0];
      end else if (final_xfer) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        last_q  <= 1'b0;
      end else if (xfer) begin
        row_q  <= row_d;
        col_q  <= col_d;
        last_q <= last_d;
        data_q <= snap_q[row_d][col_d];
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign out_last   = last_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain using the reference frame
// C[i][j] = (j+1)*(126i+91), optionally scaled.
module tb_systolic_result_drain;

  localparam int SIZE = 6;
  localparam int DW   = 32;
  localparam int EW   = 2 * DW;
  localparam int IW   = 3;

  logic                                clk = 1'b0;
  logic                                rst;
  logic                                done;
  logic [0:SIZE-1][0:SIZE-1][EW-1:0]   result;
  logic                                out_valid;
  logic                                out_ready;
  logic [EW-1:0]                       out_data;
  logic [IW-1:0]                       out_row;
  logic [IW-1:0]                       out_col;
  logic                                out_last;
  logic                                busy;
  logic                                frame_done;
  logic                                overrun;

  int n_checks = 0;
  int n_pass   = 0;

  systolic_result_drain #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .result     (result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [63:0] c_val(input int i, input int j, input int scale);
    return 64'(scale * (j + 1) * (126 * i + 91));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_result(input int scale);
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        result[i][j] = c_val(i, j, scale);
  endtask

  task automatic check_beat(input string tag, input int k, input int scale);
    check({tag, " valid"}, 64'(out_valid), 64'd1);
    check({tag, " data"},  out_data, c_val(k / SIZE, k % SIZE, scale));
    check({tag, " row"},   64'(out_row), 64'(k / SIZE));
    check({tag, " col"},   64'(out_col), 64'(k % SIZE));
    check({tag, " last"},  64'(out_last), 64'(k == SIZE * SIZE - 1));
  endtask

  // Fresh done edge: low for one edge, high on the next; beat 0 is then presented.
  task automatic start_frame(input int scale);
    load_result(scale);
    done = 1'b0;
    step();
    done = 1'b1;
    step();
    check("start busy", 64'(busy), 64'd1);
  endtask

  // Drains one frame whose beat 0 is already presented. Negative beat numbers
  // disable the corresponding feature.
  task automatic stream(input string tag, input int scale, input int stall_beat,
                        input int pulse_beat, input bit chain, input int abort_beat,
                        input bit zero_live, input bit exp_ovr);
    for (int k = 0; k < SIZE * SIZE; k++) begin
      if (k == abort_beat) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check({tag, " abort valid"}, 64'(out_valid), 64'd0);
        check({tag, " abort busy"},  64'(busy), 64'd0);
        check({tag, " abort ovr"},   64'(overrun), 64'd0);
        step();
        check({tag, " abort no fd"}, 64'(frame_done), 64'd0);
        check({tag, " abort idle"},  64'(out_valid), 64'd0);
        return;
      end
      check_beat($sformatf("%s beat%0d", tag, k), k, scale);
      if (k == stall_beat) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          check_beat($sformatf("%s stall%0d", tag, s), k, scale);
        end
        out_ready = 1'b1;
      end
      if (k == 0 && zero_live) result = '0;
      if (k == pulse_beat) done = 1'b0;
      if (k == pulse_beat + 1) done = 1'b1;
      if (pulse_beat >= 0 && k == pulse_beat + 2)
        check({tag, " overrun set"}, 64'(overrun), 64'd1);
      if (chain && k == SIZE * SIZE - 2) done = 1'b0;
      if (chain && k == SIZE * SIZE - 1) begin
        done = 1'b1;
        load_result(2);
      end
      step();
    end
    check({tag, " frame_done"}, 64'(frame_done), 64'd1);
    check({tag, " overrun"},    64'(overrun), 64'(exp_ovr));
    if (chain) begin
      check({tag, " chain valid"}, 64'(out_valid), 64'd1);
      check({tag, " chain busy"},  64'(busy), 64'd1);
      check({tag, " chain data"},  out_data, 64'd182);
      check({tag, " chain row"},   64'(out_row), 64'd0);
      check({tag, " chain col"},   64'(out_col), 64'd0);
    end else begin
      check({tag, " end valid"}, 64'(out_valid), 64'd0);
      check({tag, " end busy"},  64'(busy), 64'd0);
      step();
      check({tag, " fd pulse"},  64'(frame_done), 64'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    done      = 1'b1;
    out_ready = 1'b0;
    load_result(1);

    // Reset with done held high.
    step();
    step();
    check("rst valid", 64'(out_valid), 64'd0);
    check("rst last",  64'(out_last), 64'd0);
    check("rst busy",  64'(busy), 64'd0);
    check("rst fd",    64'(frame_done), 64'd0);
    check("rst ovr",   64'(overrun), 64'd0);
    check("rst data",  out_data, 64'd0);
    check("rst row",   64'(out_row), 64'd0);
    check("rst col",   64'(out_col), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("held done valid", 64'(out_valid), 64'd0);
    check("held done busy",  64'(busy), 64'd0);

    // Frame A: full rate, chained into a x2 frame on the final transfer.
    start_frame(1);
    stream("A", 1, -1, -1, 1'b1, -1, 1'b0, 1'b0);

    // Frame B: live result zeroed after capture, done pulsed mid-frame.
    stream("B", 2, -1, 10, 1'b0, -1, 1'b1, 1'b1);
    check("B ovr sticky", 64'(overrun), 64'd1);

    // Frame C: backpressure at beat 6, then reset at beat 20.
    start_frame(1);
    stream("C", 1, 6, -1, 1'b0, 20, 1'b0, 1'b0);

    // Frame D: clean full frame after the abort.
    start_frame(1);
    stream("D", 1, -1, -1, 1'b0, -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
